// File: rtl/hilo_muldiv_pkg.sv
// rtl/hilo_muldiv_pkg.sv - op codes, FSM states and op decode helpers for hilo_muldiv_seq
package hilo_muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    MD_S_IDLE     = 3'd0,
    MD_S_MUL      = 3'd1,
    MD_S_DIV_PREP = 3'd2,
    MD_S_DIV_ITER = 3'd3,
    MD_S_DIV_FIX  = 3'd4,
    MD_S_DONE     = 3'd5
  } md_state_e;

  localparam int MD_DATA_W = 32;

  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_seq_if.sv
// rtl/hilo_muldiv_seq_if.sv - EX-stage request/result bundle for the HI/LO mul/div sequencer
interface hilo_muldiv_seq_if;
  import hilo_muldiv_pkg::*;

  logic                 op_valid;
  logic [1:0]           op_code;
  logic [MD_DATA_W-1:0] op_a;
  logic [MD_DATA_W-1:0] op_b;
  logic                 flush;
  logic                 res_ack;
  logic                 stall_req;
  logic                 busy;
  logic                 res_valid;
  logic [MD_DATA_W-1:0] res_hi;
  logic [MD_DATA_W-1:0] res_lo;
  logic                 div_by_zero;

  modport master (
    output op_valid, op_code, op_a, op_b, flush, res_ack,
    input  stall_req, busy, res_valid, res_hi, res_lo, div_by_zero
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b, flush, res_ack,
    output stall_req, busy, res_valid, res_hi, res_lo, div_by_zero
  );

endinterface

// File: rtl/hilo_muldiv_seq_div_iter_core.sv
// rtl/hilo_muldiv_seq_div_iter_core.sv - restoring divider datapath, one quotient bit per step
module hilo_muldiv_seq_div_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dsor_q, dsor_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // The dividend is shifted out of the quotient register MSB-first as quotient bits shift in.
  always_comb begin
    shifted = {rem_q, quot_q[WIDTH-1]};
    diff    = shifted - {1'b0, dsor_q};
    rem_d   = rem_q;
    quot_d  = quot_q;
    dsor_d  = dsor_q;
    if (load) begin
      rem_d  = '0;
      quot_d = dividend;
      dsor_d = divisor;
    end else if (step) begin
      rem_d  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      quot_d = {quot_q[WIDTH-2:0], ~diff[WIDTH]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      dsor_q <= '0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dsor_q <= dsor_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv_seq.sv
// rtl/hilo_muldiv_seq.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer producing an EX-stage HI+LO write
module hilo_muldiv_seq
  import hilo_muldiv_pkg::*;
#(
  parameter int MUL_LATENCY = 2,
  parameter int DIV_WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst,
  hilo_muldiv_seq_if.slave bus
);

  localparam int CNT_MAX = (DIV_WIDTH > MUL_LATENCY) ? DIV_WIDTH : MUL_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  md_state_e        state_q, state_d;
  logic [1:0]       op_code_q, op_code_d;
  logic [31:0]      op_a_q, op_a_d;
  logic [31:0]      op_b_q, op_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_q, dbz_d;
  logic [31:0]      res_hi_q, res_hi_d;
  logic [31:0]      res_lo_q, res_lo_d;

  logic             op_signed;
  logic             mul_last;
  logic             div_last;
  logic [63:0]      mul_a, mul_b, mul_prod, mul_tap;
  logic [31:0]      a_abs, b_abs, div_quot, div_rem;

  assign op_signed = is_signed_op(op_code_q);
  assign mul_last  = (cnt_q == CNT_W'(MUL_LATENCY - 1));
  assign div_last  = (cnt_q == '0);

  // Low 64 bits of the 33x33 product equal the low 64 bits of the 64-bit extended product.
  assign mul_a    = op_signed ? {{32{op_a_q[31]}}, op_a_q} : {32'd0, op_a_q};
  assign mul_b    = op_signed ? {{32{op_b_q[31]}}, op_b_q} : {32'd0, op_b_q};
  assign mul_prod = mul_a * mul_b;

  generate
    if (MUL_LATENCY == 1) begin : g_mul_direct
      assign mul_tap = mul_prod;
    end else begin : g_mul_pipe
      logic [63:0] pipe_q [MUL_LATENCY-1];
      always_ff @(posedge clk) begin
        pipe_q[0] <= mul_prod;
        for (int i = 1; i < MUL_LATENCY - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
      assign mul_tap = pipe_q[MUL_LATENCY-2];
    end
  endgenerate

  assign a_abs = (op_signed && op_a_q[31]) ? -op_a_q : op_a_q;
  assign b_abs = (op_signed && op_b_q[31]) ? -op_b_q : op_b_q;

  hilo_muldiv_seq_div_iter_core #(.WIDTH(DIV_WIDTH)) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .load      (state_q == MD_S_DIV_PREP),
    .step      (state_q == MD_S_DIV_ITER),
    .dividend  (a_abs),
    .divisor   (b_abs),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = MD_S_IDLE;
    end else begin
      case (state_q)
        MD_S_IDLE:     if (bus.op_valid) state_d = is_div_op(bus.op_code) ? MD_S_DIV_PREP : MD_S_MUL;
        MD_S_MUL:      if (mul_last) state_d = MD_S_DONE;
        MD_S_DIV_PREP: state_d = (op_b_q == '0) ? MD_S_DONE : MD_S_DIV_ITER;
        MD_S_DIV_ITER: if (div_last) state_d = MD_S_DIV_FIX;
        MD_S_DIV_FIX:  state_d = MD_S_DONE;
        MD_S_DONE:     if (bus.res_ack) state_d = MD_S_IDLE;
        default:       state_d = MD_S_IDLE;
      endcase
    end
  end

  always_comb begin
    op_code_d  = op_code_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    cnt_d      = cnt_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    dbz_d      = dbz_q;
    res_hi_d   = res_hi_q;
    res_lo_d   = res_lo_q;
    if (bus.flush) begin
      dbz_d = 1'b0;
    end else begin
      case (state_q)
        MD_S_IDLE: begin
          if (bus.op_valid) begin
            op_code_d = bus.op_code;
            op_a_d    = bus.op_a;
            op_b_d    = bus.op_b;
            cnt_d     = '0;
          end
        end
        MD_S_MUL: begin
          cnt_d = cnt_q + 1'b1;
          if (mul_last) {res_hi_d, res_lo_d} = mul_tap;
        end
        MD_S_DIV_PREP: begin
          neg_quot_d = op_signed & (op_a_q[31] ^ op_b_q[31]);
          neg_rem_d  = op_signed & op_a_q[31];
          cnt_d      = CNT_W'(DIV_WIDTH - 1);
          if (op_b_q == '0) begin
            res_hi_d = op_a_q;
            res_lo_d = '1;
            dbz_d    = 1'b1;
          end
        end
        MD_S_DIV_ITER: begin
          if (!div_last) cnt_d = cnt_q - 1'b1;
        end
        MD_S_DIV_FIX: begin
          res_lo_d = neg_quot_q ? -div_quot : div_quot;
          res_hi_d = neg_rem_q ? -div_rem : div_rem;
        end
        MD_S_DONE: begin
          if (bus.res_ack) dbz_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_code_q  <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_q      <= 1'b0;
      res_hi_q   <= '0;
      res_lo_q   <= '0;
    end else begin
      op_code_q  <= op_code_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      cnt_q      <= cnt_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      dbz_q      <= dbz_d;
      res_hi_q   <= res_hi_d;
      res_lo_q   <= res_lo_d;
    end
  end

  // In IDLE the stall is combinational so EX is held in the very cycle the op is accepted.
  always_comb begin
    bus.busy        = (state_q != MD_S_IDLE);
    bus.res_valid   = (state_q == MD_S_DONE);
    bus.stall_req   = (state_q == MD_S_IDLE) ? (bus.op_valid & ~bus.flush)
                                             : (state_q != MD_S_DONE);
    bus.res_hi      = res_hi_q;
    bus.res_lo      = res_lo_q;
    bus.div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// tb/tb_hilo_muldiv_seq.sv - self-checking bench for hilo_muldiv_seq
module tb_hilo_muldiv_seq;
  import hilo_muldiv_pkg::*;

  localparam int MUL_LAT = 2;
  localparam int DIV_W   = 32;
  localparam int NV      = 10;
  localparam int NRAND   = 40;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vec [NV];

  hilo_muldiv_seq_if bus ();

  hilo_muldiv_seq #(.MUL_LATENCY(MUL_LAT), .DIV_WIDTH(DIV_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo,
                                    output logic dbz, output int lat);
    longint      sa, sb;
    logic [63:0] ua, ub, t;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    dbz = 1'b0;
    lat = MUL_LAT + 1;
    case (op)
      2'd0: begin t = 64'(sa * sb); hi = t[63:32]; lo = t[31:0]; end
      2'd1: begin t = ua * ub;      hi = t[63:32]; lo = t[31:0]; end
      default: begin
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1; lat = 2;
        end else begin
          lat = DIV_W + 3;
          if (op == 2'd2) begin
            t = 64'(sa / sb); lo = t[31:0];
            t = 64'(sa % sb); hi = t[31:0];
          end else begin
            t = ua / ub; lo = t[31:0];
            t = ua % ub; hi = t[31:0];
          end
        end
      end
    endcase
  endfunction

  // Called just after a rising edge; returns at the falling edge of the first res_valid cycle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dbz,
                        output int lat, output int stalls, output logic done_stall,
                        output logic busy0);
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    bus.op_a     = a;
    bus.op_b     = b;
    hi = '0; lo = '0; dbz = 1'b0; done_stall = 1'b1; busy0 = 1'b1;
    lat = 100; stalls = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) busy0 = bus.busy;
      if (bus.res_valid) begin
        hi = bus.res_hi; lo = bus.res_lo; dbz = bus.div_by_zero;
        done_stall = bus.stall_req;
        lat = i;
        break;
      end
      if (bus.stall_req) stalls++;
      if (i == 1) begin
        bus.op_a    = $urandom;
        bus.op_b    = $urandom;
        bus.op_code = 2'($urandom);
      end
    end
  endtask

  task automatic ack_done(input string tag);
    bus.res_ack  = 1'b1;
    bus.op_valid = 1'b0;
    @(posedge clk);
    #1 bus.res_ack = 1'b0;
    @(negedge clk);
    check({tag, " busy after ack"}, 64'(bus.busy), 64'(0));
    check({tag, " valid after ack"}, 64'(bus.res_valid), 64'(0));
    check({tag, " dbz after ack"}, 64'(bus.div_by_zero), 64'(0));
  endtask

  task automatic check_result(input string tag, input vec_t e, input logic [31:0] hi,
                              input logic [31:0] lo, input logic dbz, input int lat,
                              input int stalls, input logic dstall, input logic busy0);
    check({tag, " hi"}, 64'(hi), 64'(e.hi));
    check({tag, " lo"}, 64'(lo), 64'(e.lo));
    check({tag, " dbz"}, 64'(dbz), 64'(e.dbz));
    check({tag, " latency"}, 64'(lat), 64'(e.lat));
    check({tag, " stall cycles"}, 64'(stalls), 64'(e.lat));
    check({tag, " stall in done"}, 64'(dstall), 64'(0));
    check({tag, " busy at accept"}, 64'(busy0), 64'(0));
  endtask

  initial begin
    logic [31:0] hi, lo, ehi, elo;
    logic        dbz, edbz, dstall, busy0;
    int          lat, elat, stalls, rcount;
    vec_t        e;

    vec[0] = '{MD_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, MUL_LAT + 1};
    vec[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, MUL_LAT + 1};
    vec[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35};
    vec[3] = '{MD_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        1'b0, 35};
    vec[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 35};
    vec[5] = '{MD_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b1, 2};
    vec[6] = '{MD_DIV,   32'hFFFF_FFF7, 32'd0,        32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1, 2};
    vec[7] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, MUL_LAT + 1};
    vec[8] = '{MD_DIVU,  32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF, 1'b0, 35};
    vec[9] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 35};

    rst = 1'b1;
    bus.op_valid = 1'b0; bus.op_code = '0; bus.op_a = '0; bus.op_b = '0;
    bus.flush = 1'b0; bus.res_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset stall_req", 64'(bus.stall_req), 64'(0));
    check("reset busy", 64'(bus.busy), 64'(0));
    check("reset res_valid", 64'(bus.res_valid), 64'(0));
    check("reset div_by_zero", 64'(bus.div_by_zero), 64'(0));
    check("reset res_hi", 64'(bus.res_hi), 64'(0));
    check("reset res_lo", 64'(bus.res_lo), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      run_op(vec[i].op, vec[i].a, vec[i].b, hi, lo, dbz, lat, stalls, dstall, busy0);
      check_result($sformatf("vec%0d", i), vec[i], hi, lo, dbz, lat, stalls, dstall, busy0);
      ack_done($sformatf("vec%0d", i));
    end

    for (int i = 0; i < NRAND; i++) begin
      e.op = 2'($urandom);
      e.a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       e.b = 32'd0;
        1:       e.b = 32'hFFFF_FFFF;
        2:       e.b = 32'd1;
        3:       e.b = 32'($urandom_range(2, 300));
        default: e.b = $urandom;
      endcase
      ref_model(e.op, e.a, e.b, ehi, elo, edbz, elat);
      e.hi = ehi; e.lo = elo; e.dbz = edbz; e.lat = elat;
      @(posedge clk); #1;
      run_op(e.op, e.a, e.b, hi, lo, dbz, lat, stalls, dstall, busy0);
      check_result($sformatf("rand%0d op%0d a=%h b=%h", i, e.op, e.a, e.b), e, hi, lo, dbz, lat, stalls,
                   dstall, busy0);
      ack_done($sformatf("rand%0d", i));
    end

    // Flush during divide iteration 10, then a MULTU issued the very next cycle.
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_code = MD_DIV; bus.op_a = 32'd1000; bus.op_b = 32'd3;
    rcount = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.res_valid) rcount++;
      @(posedge clk); #1;
    end
    bus.flush = 1'b1; bus.op_valid = 1'b0;
    @(negedge clk);
    check("flush cycle stall_req", 64'(bus.stall_req), 64'(1));
    if (bus.res_valid) rcount++;
    check("flushed div res_valid count", 64'(rcount), 64'(0));
    @(posedge clk);
    #1 bus.flush = 1'b0;
    e = '{MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 32'h242D_2080, 1'b0, MUL_LAT + 1};
    run_op(e.op, e.a, e.b, hi, lo, dbz, lat, stalls, dstall, busy0);
    check_result("post-flush multu", e, hi, lo, dbz, lat, stalls, dstall, busy0);
    ack_done("post-flush multu");

    // flush together with op_valid in IDLE accepts nothing.
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.flush = 1'b1; bus.op_code = MD_MULT; bus.op_a = 32'd9; bus.op_b = 32'd9;
    @(negedge clk);
    check("idle flush stall_req", 64'(bus.stall_req), 64'(0));
    @(posedge clk);
    #1 bus.op_valid = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    check("idle flush busy", 64'(bus.busy), 64'(0));

    // DONE held three cycles with op_valid high and no ack.
    @(posedge clk); #1;
    e = '{MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 35};
    run_op(e.op, e.a, e.b, hi, lo, dbz, lat, stalls, dstall, busy0);
    check_result("hold divu", e, hi, lo, dbz, lat, stalls, dstall, busy0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d res_valid", k), 64'(bus.res_valid), 64'(1));
      check($sformatf("hold%0d hi", k), 64'(bus.res_hi), 64'(2));
      check($sformatf("hold%0d lo", k), 64'(bus.res_lo), 64'(14));
      check($sformatf("hold%0d busy", k), 64'(bus.busy), 64'(1));
      check($sformatf("hold%0d stall_req", k), 64'(bus.stall_req), 64'(0));
    end
    ack_done("hold divu");

    // res_ack and flush in the same DONE cycle.
    @(posedge clk); #1;
    e = '{MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 2};
    run_op(e.op, e.a, e.b, hi, lo, dbz, lat, stalls, dstall, busy0);
    check_result("ack+flush dbz", e, hi, lo, dbz, lat, stalls, dstall, busy0);
    bus.flush = 1'b1;
    ack_done("ack+flush");
    bus.flush = 1'b0;

    // Reset in the middle of a divide discards everything.
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_code = MD_DIVU; bus.op_a = 32'd9; bus.op_b = 32'd2;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; bus.op_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid-op reset busy", 64'(bus.busy), 64'(0));
    check("mid-op reset res_valid", 64'(bus.res_valid), 64'(0));
    check("mid-op reset res_hi", 64'(bus.res_hi), 64'(0));
    check("mid-op reset res_lo", 64'(bus.res_lo), 64'(0));
    check("mid-op reset stall_req", 64'(bus.stall_req), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
